// File: rtl/io_pkg.sv
// Shared constants and the output-FIFO payload type for the core IO channel bank.
package io_pkg;

  localparam int unsigned IO_CH_STATUS = 0;
  localparam int unsigned IO_NUM_CH    = 8;
  localparam int unsigned STAT_OVF_BIT = 0;
  localparam int unsigned IO_SEL_W     = 3;
  localparam int unsigned IO_CH_W      = 15;

  typedef struct packed {
    logic [IO_SEL_W-1:0] sel;
    logic [IO_CH_W-1:0]  data;
  } io_out_t;

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module io_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/io_channel_bank.sv
// Responder end of the core IO channel: 8 channel registers, status/pending
// tracking, core-write forwarding through an output FIFO and an external write port.
module io_channel_bank
  import io_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned CH_W      = IO_CH_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [IO_SEL_W-1:0] IO_read_sel,
  input  logic                IO_read_en,
  output logic [CH_W-1:0]     IO_read_data,
  input  logic [IO_SEL_W-1:0] IO_write_sel,
  input  logic [CH_W-1:0]     IO_write_data,
  input  logic                IO_write_en,
  output logic                out_valid,
  output logic [IO_SEL_W-1:0] out_sel,
  output logic [CH_W-1:0]     out_data,
  input  logic                out_ready,
  input  logic                in_valid,
  input  logic [IO_SEL_W-1:0] in_sel,
  input  logic [CH_W-1:0]     in_data,
  output logic                in_ready,
  output logic                irq
);

  logic [CH_W-1:0]        ch_q [1:IO_NUM_CH-1];
  logic [CH_W-1:0]        ch_d [1:IO_NUM_CH-1];
  logic [IO_NUM_CH-1:1]   pending_q, pending_d;
  logic                   ovf_q, ovf_d;
  logic                   irq_q, irq_d;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   in_accept;
  logic                   wr_status;
  io_out_t                fifo_head;
  io_out_t                fifo_in;

  assign wr_status = (IO_write_sel == IO_SEL_W'(IO_CH_STATUS));
  assign fifo_push = IO_write_en && !wr_status;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_in   = '{sel: IO_write_sel, data: IO_write_data};

  // Core wins a same-channel collision; the external side must retry.
  assign in_accept = in_valid && !(IO_write_en && (IO_write_sel == in_sel));
  assign in_ready  = in_accept;

  assign out_valid = !fifo_empty;
  assign out_sel   = fifo_head.sel;
  assign out_data  = fifo_head.data;
  assign irq       = irq_q;

  always_comb begin
    if (IO_read_sel == IO_SEL_W'(IO_CH_STATUS)) begin
      IO_read_data = CH_W'({pending_q, ovf_q});
    end else begin
      IO_read_data = ch_q[IO_read_sel];
    end
  end

  // Clears are applied first so that an external set in the same cycle wins.
  always_comb begin
    ch_d      = ch_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    irq_d     = |pending_q;
    if (IO_read_en && (IO_read_sel != IO_SEL_W'(IO_CH_STATUS))) begin
      pending_d[IO_read_sel] = 1'b0;
    end
    if (IO_write_en) begin
      if (wr_status) begin
        pending_d = pending_d & ~IO_write_data[IO_NUM_CH-1:1];
        if (IO_write_data[STAT_OVF_BIT]) begin
          ovf_d = 1'b0;
        end
      end else begin
        ch_d[IO_write_sel] = IO_write_data;
        if (fifo_full && !fifo_pop) begin
          ovf_d = 1'b1;
        end
      end
    end
    if (in_accept && (in_sel != IO_SEL_W'(IO_CH_STATUS))) begin
      ch_d[in_sel]      = in_data;
      pending_d[in_sel] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < int'(IO_NUM_CH); i++) begin
        ch_q[i] <= '0;
      end
      pending_q <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  io_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .T     (io_out_t)
  ) u_out_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_io_channel_bank.sv
// Bench for io_channel_bank: directed scenarios followed by random traffic,
// all compared against a queue/array model of the channel bank.
module tb_io_channel_bank;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic [2:0]  IO_read_sel;
  logic        IO_read_en;
  logic [14:0] IO_read_data;
  logic [2:0]  IO_write_sel;
  logic [14:0] IO_write_data;
  logic        IO_write_en;
  logic        out_valid;
  logic [2:0]  out_sel;
  logic [14:0] out_data;
  logic        out_ready;
  logic        in_valid;
  logic [2:0]  in_sel;
  logic [14:0] in_data;
  logic        in_ready;
  logic        irq;

  io_channel_bank #(.OUT_DEPTH(DEPTH), .CH_W(15)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .IO_read_sel   (IO_read_sel),
    .IO_read_en    (IO_read_en),
    .IO_read_data  (IO_read_data),
    .IO_write_sel  (IO_write_sel),
    .IO_write_data (IO_write_data),
    .IO_write_en   (IO_write_en),
    .out_valid     (out_valid),
    .out_sel       (out_sel),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .in_valid      (in_valid),
    .in_sel        (in_sel),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .irq           (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [14:0] m_ch [8];
  logic [7:0]  m_pend;
  logic        m_ovf;
  logic        m_irq;
  logic [17:0] m_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ch[i] = '0;
    m_pend = '0;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    m_q.delete();
  endtask

  function automatic logic [14:0] model_read(input logic [2:0] sel);
    if (sel == 3'd0) return {7'b0, m_pend[7:1], m_ovf};
    return m_ch[sel];
  endfunction

  function automatic logic model_accept();
    return in_valid && !(IO_write_en && (IO_write_sel == in_sel));
  endfunction

  // Applies one clock edge worth of the channel-bank rules to the model.
  task automatic model_edge();
    logic next_irq;
    next_irq = |m_pend[7:1];
    if (m_q.size() > 0 && out_ready) m_q.delete(0);
    if (IO_read_en && IO_read_sel != 3'd0) m_pend[IO_read_sel] = 1'b0;
    if (IO_write_en) begin
      if (IO_write_sel == 3'd0) begin
        for (int i = 1; i < 8; i++) if (IO_write_data[i]) m_pend[i] = 1'b0;
        if (IO_write_data[0]) m_ovf = 1'b0;
      end else begin
        m_ch[IO_write_sel] = IO_write_data;
        if (m_q.size() < DEPTH) m_q.push_back({IO_write_sel, IO_write_data});
        else m_ovf = 1'b1;
      end
    end
    if (model_accept() && in_sel != 3'd0) begin
      m_ch[in_sel]   = in_data;
      m_pend[in_sel] = 1'b1;
    end
    m_irq = next_irq;
  endtask

  // Called just after a rising edge with inputs set; checks, then advances one edge.
  task automatic cycle();
    #2;
    chk("rd_data", IO_read_data, model_read(IO_read_sel));
    chk("in_ready", in_ready, model_accept());
    chk("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("out_head", {out_sel, out_data}, m_q[0]);
    chk("irq", irq, m_irq);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    IO_read_en  = 1'b0;
    IO_write_en = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    IO_read_sel   = '0;
    IO_read_en    = 1'b0;
    IO_write_sel  = '0;
    IO_write_data = '0;
    IO_write_en   = 1'b0;
    out_ready     = 1'b0;
    in_valid      = 1'b0;
    in_sel        = '0;
    in_data       = '0;
    model_reset();

    // 1) reset state
    #2;
    for (int i = 0; i < 8; i++) begin
      IO_read_sel = 3'(i);
      #1;
      chk("reset_rd", IO_read_data, 15'd0);
    end
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_irq", irq, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    IO_read_sel = '0;

    // 2) core write ch3, head held while out_ready low
    IO_write_en = 1'b1; IO_write_sel = 3'd3; IO_write_data = 15'o12345;
    cycle();
    idle();
    IO_read_sel = 3'd3;
    #1;
    chk("t2_rd_ch3", IO_read_data, 15'o12345);
    chk("t2_out", {out_valid, out_sel, out_data}, {1'b1, 3'd3, 15'o12345});
    cycle();
    cycle();
    chk("t2_hold", {out_valid, out_sel, out_data}, {1'b1, 3'd3, 15'o12345});
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // 3) overflow on 5th write, then write-1-to-clear
    for (int i = 1; i <= 5; i++) begin
      IO_write_en = 1'b1; IO_write_sel = 3'(i); IO_write_data = 15'(16'h0100 + i);
      cycle();
    end
    idle();
    IO_read_sel = 3'd0;
    #1;
    chk("t3_status_ovf", IO_read_data, 15'h0001);
    chk("t3_head", {out_sel, out_data}, {3'd1, 15'h0101});
    IO_write_en = 1'b1; IO_write_sel = 3'd0; IO_write_data = 15'h0001;
    cycle();
    idle();
    #1;
    chk("t3_status_clr", IO_read_data, 15'h0000);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    idle();

    // 4) external write sets pending and irq; read_en clears them
    in_valid = 1'b1; in_sel = 3'd5; in_data = 15'h1ABC;
    #1;
    chk("t4_in_ready", in_ready, 1'b1);
    cycle();
    idle();
    IO_read_sel = 3'd5;
    #1;
    chk("t4_rd_ch5", IO_read_data, 15'h1ABC);
    chk("t4_irq_lag", irq, 1'b0);
    cycle();
    IO_read_sel = 3'd0;
    #1;
    chk("t4_status", IO_read_data, 15'h0020);
    chk("t4_irq", irq, 1'b1);
    IO_read_sel = 3'd5; IO_read_en = 1'b1;
    cycle();
    idle();
    IO_read_sel = 3'd0;
    #1;
    chk("t4_status_clr", IO_read_data, 15'h0000);
    cycle();
    #1;
    chk("t4_irq_clr", irq, 1'b0);

    // 5) core/external collision on ch2, then external retry
    IO_write_en = 1'b1; IO_write_sel = 3'd2; IO_write_data = 15'h0123;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 15'h7777;
    #1;
    chk("t5_collide_ready", in_ready, 1'b0);
    cycle();
    IO_write_en = 1'b0;
    IO_read_sel = 3'd2;
    #1;
    chk("t5_rd_core", IO_read_data, 15'h0123);
    chk("t5_retry_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("t5_rd_ext", IO_read_data, 15'h7777);
    out_ready = 1'b1;
    cycle();
    cycle();
    idle();
    IO_read_sel = 3'd2; IO_read_en = 1'b1;
    cycle();
    idle();

    // 6) full FIFO with simultaneous pop and push, wrap over 3*DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      IO_write_en = 1'b1; IO_write_sel = 3'(1 + i % 7); IO_write_data = 15'(16'h2000 + i);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      IO_write_sel = 3'(1 + (i + 3) % 7); IO_write_data = 15'(16'h3000 + i);
      cycle();
    end
    IO_write_en = 1'b0; out_ready = 1'b0;
    IO_read_sel = 3'd0;
    #1;
    chk("t6_no_ovf", IO_read_data, 15'h0000);
    chk("t6_head", {out_valid, out_sel, out_data}, {1'b1, m_q[0]});

    // 1b) reset asserted mid-burst with a full FIFO
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_status", IO_read_data, 15'h0000);
    model_reset();
    #1;
    reset_n = 1'b1;
    cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      IO_write_en   = ($urandom_range(0, 2) == 0);
      IO_write_sel  = 3'($urandom_range(0, 7));
      IO_write_data = 15'($urandom);
      IO_read_en    = ($urandom_range(0, 3) == 0);
      IO_read_sel   = 3'($urandom_range(0, 7));
      in_valid      = ($urandom_range(0, 2) == 0);
      in_sel        = ($urandom_range(0, 3) == 0) ? IO_write_sel : 3'($urandom_range(0, 7));
      in_data       = 15'($urandom);
      out_ready     = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
